flow_counter_update: RTL and testbench
======================================

// Module: flow_counter_update
// PURPOSE
//  Downstream calculation stage of the per-flow BRAM lookup stage.
//  - Takes the counter word fetched for a flow plus the packet length, and returns the
//    updated word with flow ID for write-back to the same BRAM bank.
//  - Flags heavy-hitter threshold crossings and keeps error/saturation statistics.
// PARAMETERS
//  COUNTER_WIDTH  64  width of packed counter word {pkt_cnt, byte_cnt}
//  PKT_CNT_WIDTH  24  MSB field: packet count; byte_cnt = remaining COUNTER_WIDTH-PKT_CNT_WIDTH bits
//  LENTH_WIDTH    16  packet length field width (bytes)
//  ID_WIDTH       12  flow ID / BRAM address width
//  SATCNT_WIDTH   16  width of saturation event counter
// PORTS
//  clk                 in   1              clock
//  reset_n             in   1              synchronous, active-low reset
//  enable              in   1              accept new requests when high
//  counter_valid       in   1              1-cycle request strobe from lookup stage
//  counter_data        in   COUNTER_WIDTH  current counter word read from BRAM
//  lenth_data          in   LENTH_WIDTH    packet length to add
//  id_data             in   ID_WIDTH       flow ID of request
//  hh_threshold        in   COUNTER_WIDTH-PKT_CNT_WIDTH  byte threshold; 0 = detection off
//  stats_clear         in   1              clears overrun_err and sat_count
//  update_c_valid      out  1              1-cycle write-back strobe to lookup stage
//  update_counter_data out  COUNTER_WIDTH  updated counter word
//  update_id_data      out  ID_WIDTH       flow ID for write-back
//  busy                out  1              request in flight
//  hh_valid            out  1              1-cycle heavy-hitter event
//  hh_id               out  ID_WIDTH       flow ID of event
//  hh_bytes            out  COUNTER_WIDTH-PKT_CNT_WIDTH  new byte count at event
//  overrun_err         out  1              sticky: request arrived while busy
//  sat_count           out  SATCNT_WIDTH   number of updates where any field saturated
// BEHAVIOUR
//  Reset: every output is 0 and the FSM is in IDLE. Reset mid-operation aborts the op with no update_c_valid.
//  FSM: IDLE -> CALC -> OUT -> IDLE.
//   IDLE: if counter_valid && enable, register all three inputs and go to CALC.
//         If counter_valid && !enable, ignore the request and stay in IDLE.
//   CALC: compute new fields into registers.
//         byte_new = byte_old + lenth_data; pkt_new = pkt_old + 1.
//   OUT:  update_c_valid=1 for exactly one cycle, with update_counter_data and update_id_data valid.
//         Return to IDLE.
//  Latency: counter_valid at cycle t -> update_c_valid at t+2. Throughput: one request per 3 cycles.
//  Output hold: update_counter_data/update_id_data hold their values until the next OUT.
//  busy: high in CALC and OUT.
//  Overrun: counter_valid while busy -> request dropped, overrun_err set.
//   The in-flight op is unaffected.
//  Enable: deasserting enable mid-op does not abort the op; it completes.
//  Saturation: each field is computed with a 1-bit carry.
//   On overflow the field clamps to all-ones (other field still updates normally).
//   sat_count +1 per saturating update and holds at its max value.
//  Heavy hitter: hh_valid=1 in the OUT cycle iff hh_threshold!=0 && byte_old<hh_threshold && byte_new>=hh_threshold.
//   hh_id/hh_bytes are loaded with it and hold until the next event.
//   Already-above-threshold flows do not re-fire.
//  stats_clear: clears overrun_err and sat_count next cycle.
//   If a set event coincides with stats_clear, the set wins.
//  lenth_data=0: byte_cnt unchanged, pkt_cnt +1.
// TESTING
//  1. counter_data={24'd5,40'd1000}, lenth 64, id 7 -> t+2: update {24'd6,40'd1064}, id 7, pulse 1 cycle.
//  2. byte_cnt=2^40-10, lenth 100 -> byte_cnt=2^40-1, pkt +1, sat_count=1.
//     pkt_cnt=2^24-1 -> pkt stays 2^24-1, sat_count=2.
//  3. hh_threshold=1500, byte_old 1000, lenth 600 -> hh_valid with update, hh_id=id, hh_bytes=1600.
//     Repeat from 1600 -> no hh_valid. threshold=0 -> never fires.
//  4. Second counter_valid at t+1 -> ignored, overrun_err=1, first update correct.
//     stats_clear -> overrun_err=0.
//  5. enable=0 with counter_valid -> no update_c_valid.
//     reset_n low in CALC -> no update, all outputs 0.
//  6. Back-to-back requests every 3 cycles, 100 random ids/lengths vs model -> all updates match, overrun_err=0.

Source files
------------

// File: rtl/flow_counter_update.sv
// rtl/flow_counter_update.sv - per-flow counter update stage with saturation, heavy-hitter detect and stats
module flow_counter_update #(
  parameter int COUNTER_WIDTH = 64,
  parameter int PKT_CNT_WIDTH = 24,
  parameter int LENTH_WIDTH   = 16,
  parameter int ID_WIDTH      = 12,
  parameter int SATCNT_WIDTH  = 16
) (
  input  logic                                   clk,
  input  logic                                   reset_n,
  input  logic                                   enable,
  input  logic                                   counter_valid,
  input  logic [COUNTER_WIDTH-1:0]               counter_data,
  input  logic [LENTH_WIDTH-1:0]                 lenth_data,
  input  logic [ID_WIDTH-1:0]                    id_data,
  input  logic [COUNTER_WIDTH-PKT_CNT_WIDTH-1:0] hh_threshold,
  input  logic                                   stats_clear,
  output logic                                   update_c_valid,
  output logic [COUNTER_WIDTH-1:0]               update_counter_data,
  output logic [ID_WIDTH-1:0]                    update_id_data,
  output logic                                   busy,
  output logic                                   hh_valid,
  output logic [ID_WIDTH-1:0]                    hh_id,
  output logic [COUNTER_WIDTH-PKT_CNT_WIDTH-1:0] hh_bytes,
  output logic                                   overrun_err,
  output logic [SATCNT_WIDTH-1:0]                sat_count
);

  localparam int BYTE_WIDTH = COUNTER_WIDTH - PKT_CNT_WIDTH;

  typedef enum logic [1:0] {IDLE, CALC, OUT} state_t;

  state_t                   state;
  logic [PKT_CNT_WIDTH-1:0] req_pkt;
  logic [BYTE_WIDTH-1:0]    req_byte;
  logic [LENTH_WIDTH-1:0]   req_len;
  logic [ID_WIDTH-1:0]      req_id;

  logic [BYTE_WIDTH:0]      byte_sum;
  logic [PKT_CNT_WIDTH:0]   pkt_sum;
  logic [BYTE_WIDTH-1:0]    byte_new;
  logic [PKT_CNT_WIDTH-1:0] pkt_new;
  logic                     sat_any;
  logic                     hh_hit;
  logic                     sat_inc;
  logic                     overrun_set;

  // Each field carries one extra bit so overflow can be seen and clamped.
  always_comb begin
    byte_sum = {1'b0, req_byte} + {{(BYTE_WIDTH - LENTH_WIDTH + 1){1'b0}}, req_len};
    pkt_sum  = {1'b0, req_pkt} + {{PKT_CNT_WIDTH{1'b0}}, 1'b1};
    byte_new = byte_sum[BYTE_WIDTH] ? {BYTE_WIDTH{1'b1}} : byte_sum[BYTE_WIDTH-1:0];
    pkt_new  = pkt_sum[PKT_CNT_WIDTH] ? {PKT_CNT_WIDTH{1'b1}} : pkt_sum[PKT_CNT_WIDTH-1:0];
    sat_any  = byte_sum[BYTE_WIDTH] | pkt_sum[PKT_CNT_WIDTH];
    hh_hit   = (hh_threshold != '0) && (req_byte < hh_threshold) && (byte_new >= hh_threshold);
  end

  assign busy        = (state != IDLE);
  assign sat_inc     = (state == CALC) && sat_any;
  assign overrun_set = counter_valid && busy;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state               <= IDLE;
      req_pkt             <= '0;
      req_byte            <= '0;
      req_len             <= '0;
      req_id              <= '0;
      update_c_valid      <= 1'b0;
      update_counter_data <= '0;
      update_id_data      <= '0;
      hh_valid            <= 1'b0;
      hh_id               <= '0;
      hh_bytes            <= '0;
    end else begin
      update_c_valid <= 1'b0;
      hh_valid       <= 1'b0;
      case (state)
        IDLE: begin
          if (counter_valid && enable) begin
            req_pkt  <= counter_data[COUNTER_WIDTH-1:BYTE_WIDTH];
            req_byte <= counter_data[BYTE_WIDTH-1:0];
            req_len  <= lenth_data;
            req_id   <= id_data;
            state    <= CALC;
          end
        end
        CALC: begin
          // Results land in the output registers so they are valid during OUT.
          update_c_valid      <= 1'b1;
          update_counter_data <= {pkt_new, byte_new};
          update_id_data      <= req_id;
          if (hh_hit) begin
            hh_valid <= 1'b1;
            hh_id    <= req_id;
            hh_bytes <= byte_new;
          end
          state <= OUT;
        end
        OUT:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Statistics: a set event in the same cycle as stats_clear takes priority.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      overrun_err <= 1'b0;
      sat_count   <= '0;
    end else begin
      if (overrun_set)
        overrun_err <= 1'b1;
      else if (stats_clear)
        overrun_err <= 1'b0;

      if (sat_inc) begin
        if (sat_count != {SATCNT_WIDTH{1'b1}})
          sat_count <= sat_count + SATCNT_WIDTH'(1);
      end else if (stats_clear) begin
        sat_count <= '0;
      end
    end
  end

endmodule

// File: tb/tb_flow_counter_update.sv
// tb/tb_flow_counter_update.sv - directed self-checking bench for flow_counter_update
module tb_flow_counter_update;

  logic        clk;
  logic        reset_n;
  logic        enable;
  logic        counter_valid;
  logic [63:0] counter_data;
  logic [15:0] lenth_data;
  logic [11:0] id_data;
  logic [39:0] hh_threshold;
  logic        stats_clear;
  logic        update_c_valid;
  logic [63:0] update_counter_data;
  logic [11:0] update_id_data;
  logic        busy;
  logic        hh_valid;
  logic [11:0] hh_id;
  logic [39:0] hh_bytes;
  logic        overrun_err;
  logic [15:0] sat_count;

  int checks = 0;
  int errors = 0;

  flow_counter_update dut (
    .clk                 (clk),
    .reset_n             (reset_n),
    .enable              (enable),
    .counter_valid       (counter_valid),
    .counter_data        (counter_data),
    .lenth_data          (lenth_data),
    .id_data             (id_data),
    .hh_threshold        (hh_threshold),
    .stats_clear         (stats_clear),
    .update_c_valid      (update_c_valid),
    .update_counter_data (update_counter_data),
    .update_id_data      (update_id_data),
    .busy                (busy),
    .hh_valid            (hh_valid),
    .hh_id               (hh_id),
    .hh_bytes            (hh_bytes),
    .overrun_err         (overrun_err),
    .sat_count           (sat_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Presents one request for a single cycle; returns with the DUT in CALC.
  task automatic start_req(input logic [63:0] cnt, input logic [15:0] len, input logic [11:0] id);
    counter_valid = 1'b1;
    counter_data  = cnt;
    lenth_data    = len;
    id_data       = id;
    tick();
    counter_valid = 1'b0;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    tick();
    tick();
    checks++;
    if ({update_c_valid, update_counter_data, update_id_data, busy, hh_valid, hh_id, hh_bytes,
         overrun_err, sat_count} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got ucv=%b data=%h id=%h busy=%b hh=%b sat=%0d ovr=%b expected all 0",
               update_c_valid, update_counter_data, update_id_data, busy, hh_valid, sat_count, overrun_err);
    end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_basic;
    start_req({24'd5, 40'd1000}, 16'd64, 12'd7);
    checks++;
    if (busy !== 1'b1 || update_c_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_calc got busy=%b ucv=%b expected busy=1 ucv=0", busy, update_c_valid);
    end
    tick();
    checks++;
    if (update_c_valid !== 1'b1 || update_counter_data !== {24'd6, 40'd1064} || update_id_data !== 12'd7) begin
      errors++;
      $display("FAIL basic_out got ucv=%b data=%h id=%0d expected ucv=1 data=%h id=7",
               update_c_valid, update_counter_data, update_id_data, {24'd6, 40'd1064});
    end
    tick();
    checks++;
    if (update_c_valid !== 1'b0 || busy !== 1'b0 || update_counter_data !== {24'd6, 40'd1064}) begin
      errors++;
      $display("FAIL basic_hold got ucv=%b busy=%b data=%h expected ucv=0 busy=0 data held",
               update_c_valid, busy, update_counter_data);
    end
    start_req({24'd9, 40'd77}, 16'd0, 12'd8);
    tick();
    checks++;
    if (update_c_valid !== 1'b1 || update_counter_data !== {24'd10, 40'd77}) begin
      errors++;
      $display("FAIL zero_len got ucv=%b data=%h expected ucv=1 data=%h",
               update_c_valid, update_counter_data, {24'd10, 40'd77});
    end
    tick();
  endtask

  task automatic test_saturation;
    logic [39:0] b;
    b = 40'hFF_FFFF_FFF6;
    start_req({24'd3, b}, 16'd100, 12'd20);
    tick();
    checks++;
    if (update_counter_data !== {24'd4, 40'hFF_FFFF_FFFF} || sat_count !== 16'd1) begin
      errors++;
      $display("FAIL byte_sat got data=%h sat=%0d expected data=%h sat=1",
               update_counter_data, sat_count, {24'd4, 40'hFF_FFFF_FFFF});
    end
    tick();
    start_req({24'hFF_FFFF, 40'd0}, 16'd5, 12'd21);
    tick();
    checks++;
    if (update_counter_data !== {24'hFF_FFFF, 40'd5} || sat_count !== 16'd2) begin
      errors++;
      $display("FAIL pkt_sat got data=%h sat=%0d expected data=%h sat=2",
               update_counter_data, sat_count, {24'hFF_FFFF, 40'd5});
    end
    tick();
  endtask

  task automatic test_heavy_hitter;
    hh_threshold = 40'd1500;
    start_req({24'd1, 40'd1000}, 16'd600, 12'd11);
    tick();
    checks++;
    if (hh_valid !== 1'b1 || hh_id !== 12'd11 || hh_bytes !== 40'd1600 || update_c_valid !== 1'b1) begin
      errors++;
      $display("FAIL hh_cross got hh=%b id=%0d bytes=%0d ucv=%b expected 1 11 1600 1",
               hh_valid, hh_id, hh_bytes, update_c_valid);
    end
    tick();
    checks++;
    if (hh_valid !== 1'b0) begin
      errors++;
      $display("FAIL hh_pulse got hh=%b expected 0", hh_valid);
    end
    start_req({24'd1, 40'd1000}, 16'd500, 12'd12);
    tick();
    checks++;
    if (hh_valid !== 1'b1 || hh_id !== 12'd12 || hh_bytes !== 40'd1500) begin
      errors++;
      $display("FAIL hh_equal got hh=%b id=%0d bytes=%0d expected 1 12 1500", hh_valid, hh_id, hh_bytes);
    end
    tick();
    start_req({24'd2, 40'd1600}, 16'd600, 12'd13);
    tick();
    checks++;
    if (hh_valid !== 1'b0 || hh_id !== 12'd12 || hh_bytes !== 40'd1500 ||
        update_counter_data !== {24'd3, 40'd2200}) begin
      errors++;
      $display("FAIL hh_refire got hh=%b id=%0d bytes=%0d data=%h expected 0 12 1500 %h",
               hh_valid, hh_id, hh_bytes, update_counter_data, {24'd3, 40'd2200});
    end
    tick();
    hh_threshold = 40'd0;
    start_req({24'd0, 40'd0}, 16'd2000, 12'd14);
    tick();
    checks++;
    if (hh_valid !== 1'b0 || hh_id !== 12'd12) begin
      errors++;
      $display("FAIL hh_disabled got hh=%b id=%0d expected 0 12", hh_valid, hh_id);
    end
    tick();
  endtask

  task automatic test_overrun;
    start_req({24'd5, 40'd1000}, 16'd64, 12'd30);
    counter_valid = 1'b1;
    counter_data  = {24'd100, 40'd100};
    lenth_data    = 16'd1;
    id_data       = 12'd31;
    tick();
    counter_valid = 1'b0;
    checks++;
    if (update_c_valid !== 1'b1 || update_counter_data !== {24'd6, 40'd1064} ||
        update_id_data !== 12'd30 || overrun_err !== 1'b1) begin
      errors++;
      $display("FAIL overrun got ucv=%b data=%h id=%0d ovr=%b expected 1 %h 30 1",
               update_c_valid, update_counter_data, update_id_data, overrun_err, {24'd6, 40'd1064});
    end
    tick();
    checks++;
    if (busy !== 1'b0 || update_c_valid !== 1'b0) begin
      errors++;
      $display("FAIL overrun_drop got busy=%b ucv=%b expected 0 0", busy, update_c_valid);
    end
    stats_clear = 1'b1;
    tick();
    stats_clear = 1'b0;
    checks++;
    if (overrun_err !== 1'b0 || sat_count !== 16'd0) begin
      errors++;
      $display("FAIL stats_clear got ovr=%b sat=%0d expected 0 0", overrun_err, sat_count);
    end
    start_req({24'd1, 40'd1}, 16'd1, 12'd32);
    counter_valid = 1'b1;
    stats_clear   = 1'b1;
    tick();
    counter_valid = 1'b0;
    stats_clear   = 1'b0;
    checks++;
    if (overrun_err !== 1'b1 || update_counter_data !== {24'd2, 40'd2}) begin
      errors++;
      $display("FAIL set_wins got ovr=%b data=%h expected 1 %h", overrun_err, update_counter_data, {24'd2, 40'd2});
    end
    tick();
  endtask

  task automatic test_enable_and_abort;
    logic seen;
    seen   = 1'b0;
    enable = 1'b0;
    start_req({24'd1, 40'd1}, 16'd1, 12'd40);
    for (int i = 0; i < 4; i++) begin
      if (update_c_valid === 1'b1 || busy === 1'b1) seen = 1'b1;
      tick();
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL enable_low got activity=%b expected 0", seen);
    end
    enable = 1'b1;
    start_req({24'd7, 40'd10}, 16'd5, 12'd41);
    enable = 1'b0;
    tick();
    checks++;
    if (update_c_valid !== 1'b1 || update_counter_data !== {24'd8, 40'd15} || update_id_data !== 12'd41) begin
      errors++;
      $display("FAIL enable_midop got ucv=%b data=%h id=%0d expected 1 %h 41",
               update_c_valid, update_counter_data, update_id_data, {24'd8, 40'd15});
    end
    enable = 1'b1;
    tick();
    start_req({24'd7, 40'd10}, 16'd5, 12'd42);
    reset_n = 1'b0;
    tick();
    checks++;
    if ({update_c_valid, update_counter_data, update_id_data, busy, hh_valid, hh_id, hh_bytes,
         overrun_err, sat_count} !== '0) begin
      errors++;
      $display("FAIL abort_reset got ucv=%b data=%h id=%h busy=%b hhid=%h ovr=%b expected all 0",
               update_c_valid, update_counter_data, update_id_data, busy, hh_id, overrun_err);
    end
    reset_n = 1'b1;
    seen    = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (update_c_valid === 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL abort_no_update got ucv_seen=%b expected 0", seen);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] r;
    logic [23:0] pkt;
    logic [39:0] byt;
    logic [15:0] len;
    logic [11:0] id;
    logic [40:0] bsum;
    logic [24:0] psum;
    logic [63:0] exp_data;
    int          exp_sat;
    int          bad;
    exp_sat = 0;
    bad     = 0;
    for (int n = 0; n < 100; n++) begin
      r   = $urandom;
      pkt = (n % 10 == 3) ? 24'hFF_FFFF : r[23:0];
      r   = $urandom;
      byt = {r[7:0], $urandom};
      if (n % 10 == 6) byt = 40'hFF_FFFF_FF00;
      r   = $urandom;
      len = r[15:0];
      id  = r[27:16];
      bsum = {1'b0, byt} + {25'd0, len};
      psum = {1'b0, pkt} + 25'd1;
      exp_data = {psum[24] ? 24'hFF_FFFF : psum[23:0], bsum[40] ? 40'hFF_FFFF_FFFF : bsum[39:0]};
      if (bsum[40] || psum[24]) exp_sat++;
      start_req({pkt, byt}, len, id);
      tick();
      if (update_c_valid !== 1'b1 || update_counter_data !== exp_data || update_id_data !== id ||
          hh_valid !== 1'b0) begin
        bad++;
        if (bad <= 5)
          $display("FAIL b2b_update n=%0d got ucv=%b data=%h id=%h expected 1 %h %h",
                   n, update_c_valid, update_counter_data, update_id_data, exp_data, id);
      end
      tick();
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL b2b_summary got %0d bad updates expected 0", bad);
    end
    checks++;
    if (overrun_err !== 1'b0 || sat_count !== 16'(exp_sat)) begin
      errors++;
      $display("FAIL b2b_stats got ovr=%b sat=%0d expected 0 %0d", overrun_err, sat_count, exp_sat);
    end
  endtask

  initial begin
    reset_n       = 1'b0;
    enable        = 1'b1;
    counter_valid = 1'b0;
    counter_data  = '0;
    lenth_data    = '0;
    id_data       = '0;
    hh_threshold  = '0;
    stats_clear   = 1'b0;
    test_reset();
    test_basic();
    test_saturation();
    test_heavy_hitter();
    test_overrun();
    test_enable_and_abort();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
